// File: rtl/mem_port_arbiter.sv
// Arbitrates one instruction-fetch port and one load/store port onto a single RAM port.
// Loads/stores win by default; a starve counter caps consecutive data grants while a fetch waits.
module mem_port_arbiter #(
    parameter int unsigned WORD_ADDR_BITS = 32,
    parameter int unsigned STARVE_MAX     = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      if_req,
    input  logic [WORD_ADDR_BITS-1:0] if_addr,
    output logic                      if_done,
    output logic [31:0]               if_rdata,
    input  logic                      mem_req,
    input  logic                      mem_we,
    input  logic [1:0]                mem_ls_bit,
    input  logic [WORD_ADDR_BITS-1:0] mem_addr,
    input  logic [31:0]               mem_wdata,
    output logic                      mem_done,
    output logic [31:0]               mem_rdata,
    output logic                      mem_misalign,
    output logic                      stall_if,
    output logic                      stall_mem,
    output logic                      ram_req,
    output logic                      ram_we,
    output logic [WORD_ADDR_BITS-1:0] ram_addr,
    output logic [3:0]                ram_be,
    output logic [31:0]               ram_wdata,
    input  logic                      ram_ready,
    input  logic [31:0]               ram_rdata
);

    typedef enum logic [1:0] {StIdle, StServeIf, StServeMem, StReject} state_e;

    localparam logic [2:0] StarveMax = 3'(STARVE_MAX);

    state_e                    state_q, state_d;
    logic [2:0]                starve_q, starve_d;
    logic                      ram_we_q, ram_we_d;
    logic [WORD_ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
    logic [3:0]                ram_be_q, ram_be_d;
    logic [31:0]               ram_wdata_q, ram_wdata_d;
    logic [31:0]               if_rdata_q, mem_rdata_q;

    logic        misaligned;
    logic [3:0]  mem_be;
    logic [31:0] mem_wrep;
    logic        mem_win;
    logic        unused_if_lsb;

    assign unused_if_lsb = ^if_addr[1:0];

    // Size decode; the reserved size 11 behaves as a word.
    always_comb begin
        misaligned = 1'b0;
        mem_be     = 4'b1111;
        mem_wrep   = mem_wdata;
        case (mem_ls_bit)
            2'b01: begin
                misaligned = mem_addr[0];
                mem_be     = mem_addr[1] ? 4'b1100 : 4'b0011;
                mem_wrep   = {2{mem_wdata[15:0]}};
            end
            2'b10: begin
                mem_be   = 4'b0001 << mem_addr[1:0];
                mem_wrep = {4{mem_wdata[7:0]}};
            end
            default: misaligned = (mem_addr[1:0] != 2'b00);
        endcase
    end

    // Data port yields only when a fetch is waiting and the starve limit is reached.
    assign mem_win = mem_req && !(if_req && (starve_q == StarveMax));

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_be_d    = ram_be_q;
        ram_wdata_d = ram_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (mem_win) begin
                    if (misaligned) begin
                        state_d = StReject;
                    end else begin
                        state_d     = StServeMem;
                        ram_we_d    = mem_we;
                        ram_addr_d  = {mem_addr[WORD_ADDR_BITS-1:2], 2'b00};
                        ram_be_d    = mem_be;
                        ram_wdata_d = mem_wrep & {{8{mem_be[3]}}, {8{mem_be[2]}},
                                                  {8{mem_be[1]}}, {8{mem_be[0]}}};
                        if (if_req && (starve_q < StarveMax)) starve_d = starve_q + 3'd1;
                    end
                end else if (if_req) begin
                    state_d     = StServeIf;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = {if_addr[WORD_ADDR_BITS-1:2], 2'b00};
                    ram_be_d    = 4'b1111;
                    ram_wdata_d = '0;
                    starve_d    = '0;
                end
            end
            StServeIf, StServeMem: begin
                if (ram_ready) state_d = StIdle;
            end
            StReject: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Done pulses are suppressed during reset so an abandoned access never completes.
    assign if_done      = reset && (state_q == StServeIf) && ram_ready;
    assign mem_done     = reset && (state_q == StServeMem) && ram_ready;
    assign mem_misalign = (state_q == StReject);
    assign ram_req      = (state_q == StServeIf) || (state_q == StServeMem);
    assign ram_we       = ram_req && ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_be       = ram_be_q;
    assign ram_wdata    = ram_wdata_q;
    assign if_rdata     = if_done ? ram_rdata : if_rdata_q;
    assign mem_rdata    = mem_done ? ram_rdata : mem_rdata_q;
    assign stall_if     = if_req && !if_done;
    assign stall_mem    = mem_req && !(mem_done || mem_misalign);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_be_q    <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_be_q    <= ram_be_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata;
            mem_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected responses, a negedge
// monitor pops and compares them whenever a done/misalign pulse appears.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_ls_bit;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        mem_misalign;
    logic        stall_if;
    logic        stall_mem;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic        ram_ready;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int if_cyc = 0;
    int mem_cyc = 0;

    typedef struct {
        int          kind;   // 0 fetch, 1 load/store, 2 misalign
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] rdata;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];

    mem_port_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_done     (if_done),
        .if_rdata    (if_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ls_bit  (mem_ls_bit),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata),
        .mem_misalign(mem_misalign),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .ram_req     (ram_req),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_be      (ram_be),
        .ram_wdata   (ram_wdata),
        .ram_ready   (ram_ready),
        .ram_rdata   (ram_rdata)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Read data is a fixed function of the word address.
    assign ram_rdata = 32'hC0DE_0000 ^ ram_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic exp_t mk(input int k, input logic [31:0] a, input logic [3:0] be,
                                input logic we, input logic [31:0] rd, input logic [31:0] wd);
        exp_t e;
        e.kind = k; e.addr = a; e.be = be; e.we = we; e.rdata = rd; e.wdata = wd;
        return e;
    endfunction

    exp_t me;
    int   got;
    always @(negedge clock) begin
        if (if_done || mem_done || mem_misalign) begin
            got = if_done ? 0 : (mem_done ? 1 : 2);
            if (if_done) if_cyc = cyc;
            if (mem_done) mem_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got kind %0d, required none", got);
            end else begin
                me = sb.pop_front();
                chk("resp_kind", 32'(got), 32'(me.kind));
                if (me.kind == 2) begin
                    chk("misalign_no_ram_req", {31'd0, ram_req}, 32'd0);
                end else begin
                    chk("ram_addr", ram_addr, me.addr);
                    chk("ram_be", {28'd0, ram_be}, {28'd0, me.be});
                    chk("ram_we", {31'd0, ram_we}, {31'd0, me.we});
                    if (me.kind == 0) chk("if_rdata", if_rdata, me.rdata);
                    else if (me.we) chk("ram_wdata", ram_wdata & lane_mask(me.be), me.wdata);
                    else chk("mem_rdata", mem_rdata, me.rdata);
                end
            end
        end
    end

    task automatic if_op(input logic [31:0] a);
        int  n = 0;
        bit  seen = 0;
        if_addr = a;
        if_req  = 1'b1;
        while (!seen && n < 60) begin
            @(negedge clock);
            seen = if_done;
            n++;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL if_timeout: got no if_done, required one within 60 cycles");
        end
        @(posedge clock); #1;
        if_req = 1'b0;
    endtask

    task automatic mem_op(input logic we, input logic [1:0] ls, input logic [31:0] a,
                          input logic [31:0] wd);
        int  n = 0;
        bit  seen = 0;
        mem_we = we; mem_ls_bit = ls; mem_addr = a; mem_wdata = wd;
        mem_req = 1'b1;
        while (!seen && n < 60) begin
            @(negedge clock);
            seen = mem_done || mem_misalign;
            n++;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL mem_timeout: got no response, required one within 60 cycles");
        end else begin
            chk("stall_mem_at_resp", {31'd0, stall_mem}, 32'd0);
        end
        @(posedge clock); #1;
        mem_req = 1'b0;
    endtask

    // Keeps mem_req high across n completions, back to back.
    task automatic mem_burst(input int cnt, input logic [31:0] a);
        int n = 0;
        int done_cnt = 0;
        mem_we = 1'b0; mem_ls_bit = 2'b00; mem_addr = a; mem_wdata = '0;
        mem_req = 1'b1;
        while (done_cnt < cnt && n < 200) begin
            @(negedge clock);
            if (mem_done) done_cnt++;
            n++;
        end
        if (done_cnt < cnt) begin
            checks++; errors++;
            $display("FAIL burst_timeout: got %0d mem_done, required %0d", done_cnt, cnt);
        end
        @(posedge clock); #1;
        mem_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_ls_bit = '0; mem_addr = '0; mem_wdata = '0; ram_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ram_req", {31'd0, ram_req}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_be", {28'd0, ram_be}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_pulses", {29'd0, if_done, mem_done, mem_misalign}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Basic transactions, one at a time.
        sb.push_back(mk(0, 32'h0000_0100, 4'hF, 1'b0, 32'hC0DE_0100, 32'h0));
        if_op(32'h0000_0102);
        sb.push_back(mk(1, 32'h0000_0200, 4'hF, 1'b0, 32'hC0DE_0200, 32'h0));
        mem_op(1'b0, 2'b00, 32'h0000_0200, 32'h0);
        sb.push_back(mk(1, 32'h0000_1000, 4'b1000, 1'b1, 32'h0, 32'hAB00_0000));
        mem_op(1'b1, 2'b10, 32'h0000_1003, 32'h0000_00AB);
        sb.push_back(mk(1, 32'h0000_1000, 4'b1100, 1'b1, 32'h0, 32'h1234_0000));
        mem_op(1'b1, 2'b01, 32'h0000_1002, 32'h0000_1234);
        sb.push_back(mk(1, 32'h0000_1000, 4'b0011, 1'b0, 32'hC0DE_1000, 32'h0));
        mem_op(1'b0, 2'b01, 32'h0000_1000, 32'h0);
        sb.push_back(mk(1, 32'h0000_1000, 4'b0010, 1'b0, 32'hC0DE_1000, 32'h0));
        mem_op(1'b0, 2'b10, 32'h0000_1001, 32'h0);

        // Misaligned half, word and reserved-size accesses.
        sb.push_back(mk(2, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0));
        mem_op(1'b0, 2'b01, 32'h0000_0005, 32'h0);
        sb.push_back(mk(2, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0));
        mem_op(1'b1, 2'b00, 32'h0000_0202, 32'h5555_5555);
        sb.push_back(mk(2, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0));
        mem_op(1'b0, 2'b11, 32'h0000_0201, 32'h0);

        // Concurrent requests: data first, fetch two cycles later.
        sb.push_back(mk(1, 32'h0000_0400, 4'hF, 1'b0, 32'hC0DE_0400, 32'h0));
        sb.push_back(mk(0, 32'h0000_0500, 4'hF, 1'b0, 32'hC0DE_0500, 32'h0));
        fork
            mem_op(1'b0, 2'b00, 32'h0000_0400, 32'h0);
            if_op(32'h0000_0500);
        join
        chk("concurrent_gap", 32'(if_cyc - mem_cyc), 32'd2);

        // Starvation guard: four data grants, then the fetch, then data resumes.
        repeat (4) sb.push_back(mk(1, 32'h0000_0600, 4'hF, 1'b0, 32'hC0DE_0600, 32'h0));
        sb.push_back(mk(0, 32'h0000_0700, 4'hF, 1'b0, 32'hC0DE_0700, 32'h0));
        sb.push_back(mk(1, 32'h0000_0600, 4'hF, 1'b0, 32'hC0DE_0600, 32'h0));
        fork
            mem_burst(5, 32'h0000_0600);
            if_op(32'h0000_0700);
        join

        // Three wait states on a fetch.
        @(posedge clock); #1;
        ram_ready = 1'b0;
        sb.push_back(mk(0, 32'h0000_0340, 4'hF, 1'b0, 32'hC0DE_0340, 32'h0));
        fork
            if_op(32'h0000_0340);
            begin
                @(posedge clock);
                repeat (3) begin
                    @(negedge clock);
                    chk("wait_ram_req", {31'd0, ram_req}, 32'd1);
                    chk("wait_ram_addr", ram_addr, 32'h0000_0340);
                    chk("wait_stall_if", {31'd0, stall_if}, 32'd1);
                end
                @(posedge clock); #1;
                ram_ready = 1'b1;
            end
        join

        // Reset while a load waits on the RAM.
        @(posedge clock); #1;
        ram_ready = 1'b0;
        mem_we = 1'b0; mem_ls_bit = 2'b00; mem_addr = 32'h0000_0300; mem_req = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("pre_rst_ram_req", {31'd0, ram_req}, 32'd1);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_no_done", {31'd0, mem_done}, 32'd0);
        @(posedge clock); #1;
        chk("rst_mid_ram_req", {31'd0, ram_req}, 32'd0);
        mem_req = 1'b0;
        ram_ready = 1'b1;
        @(negedge clock);
        chk("rst_mid_no_done2", {31'd0, mem_done}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        sb.push_back(mk(0, 32'h0000_0800, 4'hF, 1'b0, 32'hC0DE_0800, 32'h0));
        if_op(32'h0000_0800);

        repeat (3) @(posedge clock);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
